// File: rtl/coprime_exponent_picker_if.sv
`default_nettype none
// coprime_exponent_picker_if: request/result bundle between the exponent picker,
// its RNG source and the consumer of the accepted exponent.
interface coprime_exponent_picker_if #(
   parameter int W = 32
) ();
   logic         start;
   logic [W-1:0] phi;
   logic [W-1:0] rng_in;
   logic         rng_en;
   logic         busy;
   logic         done;
   logic         fail;
   logic [W-1:0] e_out;
   logic [7:0]   tries;

   modport master (
      output start, phi, rng_in,
      input  rng_en, busy, done, fail, e_out, tries
   );

   modport slave (
      input  start, phi, rng_in,
      output rng_en, busy, done, fail, e_out, tries
   );
endinterface
`default_nettype wire

// File: rtl/coprime_exponent_picker.sv
`default_nettype none
// coprime_exponent_picker: draws RNG candidates until one is a valid RSA public
// exponent for phi (1 < e < phi, gcd(e,phi) == 1), using a one-step-per-cycle Stein GCD.
module coprime_exponent_picker #(
   parameter int W         = 32,
   parameter int MAX_TRIES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   coprime_exponent_picker_if.slave bus
);
   localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);
   localparam logic [W-1:0] ONE     = W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SAMPLE = 3'd2,
      GCD    = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic [W-1:0] phi_q;
   logic [W-1:0] cand;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] e_q;
   logic [7:0]   tries_q;
   logic         fail_q;

   logic [7:0]   tries_inc;
   logic         sample_reject;
   logic         gcd_done;
   logic         gcd_accept;
   logic         limit_hit;

   always_comb begin
      tries_inc     = tries_q + 8'd1;
      sample_reject = (bus.rng_in <= ONE) || (bus.rng_in >= phi_q) ||
                      (!bus.rng_in[0] && !phi_q[0]);
      gcd_done      = (a == b);
      gcd_accept    = gcd_done && (a == ONE);
      limit_hit     = 1'b0;
      state_nx      = state;
      case (state)
         IDLE:    if (bus.start) state_nx = FETCH;
         FETCH:   state_nx = SAMPLE;
         SAMPLE: begin
            if (sample_reject) begin
               // tries_inc is the count including the candidate being rejected now
               limit_hit = (tries_inc == TRY_LIMIT);
               state_nx  = limit_hit ? FINISH : FETCH;
            end else begin
               state_nx = GCD;
            end
         end
         GCD: begin
            if (gcd_accept) begin
               state_nx = FINISH;
            end else if (gcd_done) begin
               limit_hit = (tries_q == TRY_LIMIT);
               state_nx  = limit_hit ? FINISH : FETCH;
            end
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         phi_q   <= '0;
         cand    <= '0;
         a       <= '0;
         b       <= '0;
         e_q     <= '0;
         tries_q <= 8'd0;
         fail_q  <= 1'b0;
      end else begin
         state <= state_nx;
         if (limit_hit) fail_q <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  phi_q   <= bus.phi;
                  tries_q <= 8'd0;
                  fail_q  <= 1'b0;
               end
            end
            SAMPLE: begin
               cand    <= bus.rng_in;
               tries_q <= tries_inc;
               if (!sample_reject) begin
                  a <= bus.rng_in;
                  b <= phi_q;
               end
            end
            GCD: begin
               if (gcd_done) begin
                  if (gcd_accept) e_q <= cand;
               end else if (!a[0]) begin
                  a <= a >> 1;
               end else if (!b[0]) begin
                  b <= b >> 1;
               end else if (a > b) begin
                  a <= a - b;
               end else begin
                  b <= b - a;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rng_en = (state == FETCH);
   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == FINISH);
   assign bus.fail   = fail_q;
   assign bus.e_out  = e_q;
   assign bus.tries  = tries_q;
endmodule
`default_nettype wire
